// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops words from the TX FIFO and shifts them out MSB-first
// in TI-style frames (one-bit-period frame pulse, then DATA_W bits on SSPCLKOUT).
module ssp_tx_serializer #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic [DATA_W-1:0] TxDATA,
    input  logic              TX_EMPTY,
    output logic              SENT,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              TX_BUSY
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FRAME,
        S_SHIFT
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [DATA_W-1:0]  r_shift;

    logic               r_sent;
    logic               r_sclk;
    logic               r_fss;
    logic               r_txd;
    logic               r_oe_b;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic               w_div_last;
    logic               w_bit_last;
    logic               w_on_wire;
    logic               w_chained;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_bit_last = (r_bit == BIT_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;

        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                w_bit_nxt = '0;
                if (!TX_EMPTY) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
                w_shift_nxt = TxDATA;
                w_state_nxt = S_FRAME;
            end
            S_FRAME: begin
                if (w_div_last) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_last) begin
                    w_div_nxt   = '0;
                    w_shift_nxt = r_shift << 1;
                    if (w_bit_last) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = TX_EMPTY ? S_IDLE : S_LOAD;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A back-to-back LOAD keeps the pad driven so the line never floats between words.
    assign w_on_wire = (w_state_nxt == S_FRAME) || (w_state_nxt == S_SHIFT);
    assign w_chained = (w_state_nxt == S_LOAD) && (r_state == S_SHIFT);

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sent  <= 1'b0;
            r_sclk  <= 1'b0;
            r_fss   <= 1'b0;
            r_txd   <= 1'b0;
            r_oe_b  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_sent  <= (w_state_nxt == S_LOAD);
            r_sclk  <= w_on_wire && (w_div_nxt >= DIV_HALF);
            r_fss   <= (w_state_nxt == S_FRAME);
            r_txd   <= (w_state_nxt == S_SHIFT) && w_shift_nxt[DATA_W-1];
            r_oe_b  <= !(w_on_wire || w_chained);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign SENT      = r_sent;
    assign SSPCLKOUT = r_sclk;
    assign SSPFSSOUT = r_fss;
    assign SSPTXD    = r_txd;
    assign SSPOE_B   = r_oe_b;
    assign TX_BUSY   = r_busy;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Scoreboard bench for ssp_tx_serializer: two instances (CLK_DIV=2 and CLK_DIV=1) fed from
// bench FIFOs; a per-word position model predicts every pin each cycle.
module tb_ssp_tx_serializer;

    localparam int DW = 8;

    typedef struct packed {
        logic sent;
        logic sclk;
        logic fss;
        logic txd;
        logic oe_b;
        logic busy;
    } pins_t;

    logic          PCLK;
    logic          CLEAR_B;
    logic          tx_empty [2];
    logic [DW-1:0] tx_data  [2];
    logic          sent [2];
    logic          sclk [2];
    logic          fss  [2];
    logic          txd  [2];
    logic          oe_b [2];
    logic          busy [2];

    ssp_tx_serializer #(.DATA_W(DW), .CLK_DIV(2)) u_dut0 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .TxDATA(tx_data[0]), .TX_EMPTY(tx_empty[0]),
        .SENT(sent[0]), .SSPCLKOUT(sclk[0]), .SSPFSSOUT(fss[0]), .SSPTXD(txd[0]),
        .SSPOE_B(oe_b[0]), .TX_BUSY(busy[0])
    );

    ssp_tx_serializer #(.DATA_W(DW), .CLK_DIV(1)) u_dut1 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .TxDATA(tx_data[1]), .TX_EMPTY(tx_empty[1]),
        .SENT(sent[1]), .SSPCLKOUT(sclk[1]), .SSPFSSOUT(fss[1]), .SSPTXD(txd[1]),
        .SSPOE_B(oe_b[1]), .TX_BUSY(busy[1])
    );

    initial PCLK = 1'b1;
    always #5 PCLK = ~PCLK;

    // Model: m_pos = -1 idle, 0 = pop cycle, 1.. = position inside frame + data bits.
    int            m_pos   [2];
    logic [DW-1:0] m_word  [2];
    bit            m_chain [2];
    logic [DW-1:0] fifo    [2][$];
    pins_t         exp_q   [2][$];
    int            n_total;
    int            n_bad;
    int            cyc;
    pins_t         mon_exp;
    pins_t         mon_act;

    function automatic int cd_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int period_of(input int i);
        return 1 + (DW + 1) * 2 * cd_of(i);
    endfunction

    function automatic pins_t model_pins(input int i);
        pins_t p;
        int    q;
        int    slot;
        int    ph;
        p      = '0;
        p.oe_b = 1'b1;
        if (m_pos[i] == 0) begin
            p.sent = 1'b1;
            p.busy = 1'b1;
            p.oe_b = !m_chain[i];
        end else if (m_pos[i] > 0) begin
            q      = m_pos[i] - 1;
            slot   = q / (2 * cd_of(i));
            ph     = q % (2 * cd_of(i));
            p.busy = 1'b1;
            p.oe_b = 1'b0;
            p.sclk = (ph >= cd_of(i));
            if (slot == 0) p.fss = 1'b1;
            else           p.txd = m_word[i][DW-slot];
        end
        return p;
    endfunction

    task automatic drive_one(input int i, input logic rst);
        int per;
        bit mid;
        per = period_of(i);
        mid = (m_pos[i] >= 1) && (m_pos[i] <= per - 2);
        if (mid) begin
            // Mid-word the inputs are don't-care: scramble them.
            tx_empty[i] = 1'($urandom_range(0, 1));
            tx_data[i]  = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
        end else if (fifo[i].size() == 0) begin
            tx_empty[i] = 1'b1;
            tx_data[i]  = 8'($urandom);
        end else begin
            tx_empty[i] = 1'b0;
            tx_data[i]  = fifo[i][0];
        end

        if (!rst) begin
            m_pos[i]   = -1;
            m_chain[i] = 1'b0;
        end else if (m_pos[i] == -1) begin
            if (!tx_empty[i]) begin
                m_pos[i]   = 0;
                m_chain[i] = 1'b0;
            end
        end else if (m_pos[i] == 0) begin
            m_word[i] = tx_data[i];
            void'(fifo[i].pop_front());
            m_pos[i] = 1;
        end else if (m_pos[i] == per - 1) begin
            if (!tx_empty[i]) begin
                m_pos[i]   = 0;
                m_chain[i] = 1'b1;
            end else begin
                m_pos[i] = -1;
            end
        end else begin
            m_pos[i] = m_pos[i] + 1;
        end
        exp_q[i].push_back(model_pins(i));
    endtask

    task automatic step(input logic rst);
        @(negedge PCLK);
        CLEAR_B = rst;
        cyc     = cyc + 1;
        drive_one(0, rst);
        drive_one(1, rst);
    endtask

    task automatic run_idle(input string tag);
        int k;
        k = 0;
        while ((m_pos[0] != -1 || m_pos[1] != -1 || fifo[0].size() != 0 || fifo[1].size() != 0)
               && k < 2000) begin
            step(1'b1);
            k++;
        end
        n_total++;
        if (k >= 2000) begin
            n_bad++;
            $display("FAIL %s idle_timeout got=%0d cycles want<2000", tag, k);
        end
        repeat (3) step(1'b1);
    endtask

    // Monitor: pops one expected pin vector per instance per cycle.
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() > 0) begin
                    mon_exp = exp_q[i].pop_front();
                    mon_act = '{sent[i], sclk[i], fss[i], txd[i], oe_b[i], busy[i]};
                    n_total++;
                    if (mon_act !== mon_exp) begin
                        n_bad++;
                        $display("FAIL dut%0d pins cyc=%0d got=%b want=%b (sent,sclk,fss,txd,oe_b,busy)",
                                 i, cyc, mon_act, mon_exp);
                    end
                    if (mon_act.sent === 1'b1) begin
                        n_total++;
                        if (tx_empty[i] !== 1'b0) begin
                            n_bad++;
                            $display("FAIL dut%0d sent_while_empty cyc=%0d got=%b want=0",
                                     i, cyc, tx_empty[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        n_total = 0;
        n_bad   = 0;
        cyc     = 0;
        CLEAR_B = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pos[i]    = -1;
            m_word[i]   = '0;
            m_chain[i]  = 1'b0;
            tx_empty[i] = 1'b1;
            tx_data[i]  = '0;
        end

        // Reset held with a word waiting, then single word 0xA5 on both instances.
        fifo[0].push_back(8'hA5);
        fifo[1].push_back(8'hA5);
        step(1'b0);
        step(1'b0);
        run_idle("single_a5");

        // Back-to-back 0xAA, 0x02 on CLK_DIV=2; 0xFF then empty on CLK_DIV=1.
        fifo[0].push_back(8'hAA);
        fifo[0].push_back(8'h02);
        fifo[1].push_back(8'hFF);
        run_idle("b2b");

        // Reset during a data bit of 0x55; FIFO cleared alongside.
        fifo[0].push_back(8'h55);
        fifo[1].push_back(8'h55);
        k = 0;
        while (m_pos[0] != 1 + 4 * 4 + 1 && k < 200) begin
            step(1'b1);
            k++;
        end
        n_total++;
        if (k >= 200) begin
            n_bad++;
            $display("FAIL midreset reach_bit got=%0d cycles want<200", k);
        end
        fifo[0].delete();
        fifo[1].delete();
        step(1'b0);
        repeat (10) step(1'b1);

        // 0xFC with scrambled TxDATA/TX_EMPTY while shifting.
        fifo[0].push_back(8'hFC);
        fifo[1].push_back(8'hFC);
        run_idle("fc_noise");

        // Random traffic with occasional resets.
        repeat (1500) begin
            if ($urandom_range(0, 11) == 0) fifo[$urandom_range(0, 1)].push_back(8'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                fifo[0].delete();
                fifo[1].delete();
                step(1'b0);
            end else begin
                step(1'b1);
            end
        end
        run_idle("random");

        @(posedge PCLK);
        #2;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
